// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle core control path: FSM states, mux select codes
// and the bundle of control strobes that the main FSM decodes each cycle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXECR  = 4'd7,
    EXECI  = 4'd8,
    ALUWB  = 4'd9,
    BRANCH = 4'd10,
    FAULT  = 4'd11
  } state_t;

  localparam logic [1:0] SRCA_REG    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       pcs;
    logic       reg_w3;
    logic       mem_w;
    logic       fault;
  } ctrl_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles of an outstanding memory request and flags
// expiry in the cycle the count sits at WAIT_LIMIT with no ready.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic busy,
  input  logic ready,
  output logic expired
);
  localparam int CW = $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] cnt;
  logic          at_limit;

  assign at_limit = (cnt == CW'(WAIT_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (clr)                        cnt <= '0;
    else if (busy && !ready && !at_limit) cnt <= cnt + 1'b1;
  end

  // ready in the limit cycle wins over expiry
  assign expired = busy && !ready && at_limit;

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle ARM core: fetch/decode/memory/ALU sequencing,
// memory handshake with wait timeout, and a sticky fault state.
module multicycle_main_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       adr_src,
  output logic       ir_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       alu_op,
  output logic       pcs,
  output logic       reg_w3,
  output logic       mem_w,
  output logic       fault,
  output logic [3:0] state_dbg
);

  state_t state, state_nx;
  ctrl_t  ctrl;
  logic   expired;
  logic   wait_clr;
  logic   unused_funct;

  assign unused_funct = ^funct[4:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ctrl     = '0;
    case (state)
      IDLE: state_nx = FETCH;
      FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.pcs        = mem_ready;
        if (mem_ready)    state_nx = DECODE;
        else if (expired) state_nx = FAULT;
      end
      DECODE: begin
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        case (op)
          OP_DP:   state_nx = funct[5] ? EXECI : EXECR;
          OP_MEM:  state_nx = MEMADR;
          OP_BR:   state_nx = BRANCH;
          default: state_nx = FAULT;
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        state_nx       = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (mem_ready)    state_nx = MEMWB;
        else if (expired) state_nx = FAULT;
      end
      MEMWB: begin
        ctrl.result_src = RES_RDATA;
        ctrl.reg_w3     = 1'b1;
        ctrl.pcs        = (rd == 4'hF);
        state_nx        = FETCH;
      end
      MEMWR: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        ctrl.mem_w   = 1'b1;
        if (mem_ready)    state_nx = FETCH;
        else if (expired) state_nx = FAULT;
      end
      EXECR: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = 1'b1;
        state_nx       = ALUWB;
      end
      EXECI: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = 1'b1;
        state_nx       = ALUWB;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w3     = 1'b1;
        ctrl.pcs        = (rd == 4'hF);
        state_nx        = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_a  = SRCA_REG;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.result_src = RES_ALU;
        ctrl.pcs        = 1'b1;
        state_nx        = FETCH;
      end
      FAULT: begin
        ctrl.fault = 1'b1;
        state_nx   = FAULT;
      end
      default: state_nx = FAULT;
    endcase
  end

  // restart the wait count on every transition and outside memory states
  assign wait_clr = (state_nx != state) || !ctrl.mem_req;

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait (
    .clk     (clk),
    .rst_n   (reset),
    .clr     (wait_clr),
    .busy    (ctrl.mem_req),
    .ready   (mem_ready),
    .expired (expired)
  );

  assign mem_req    = ctrl.mem_req;
  assign adr_src    = ctrl.adr_src;
  assign ir_write   = ctrl.ir_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign result_src = ctrl.result_src;
  assign alu_op     = ctrl.alu_op;
  assign pcs        = ctrl.pcs;
  assign reg_w3     = ctrl.reg_w3;
  assign mem_w      = ctrl.mem_w;
  assign fault      = ctrl.fault;
  assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm (WAIT_LIMIT=3): reset, dp, load, store,
// branch, timeout/limit-cycle ready, illegal op and async reset mid-store.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       mem_ready;
  logic       mem_req, adr_src, ir_write, alu_op, pcs, reg_w3, mem_w, fault;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] state_dbg;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.WAIT_LIMIT(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
    .mem_ready(mem_ready), .mem_req(mem_req), .adr_src(adr_src),
    .ir_write(ir_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .pcs(pcs), .reg_w3(reg_w3),
    .mem_w(mem_w), .fault(fault), .state_dbg(state_dbg)
  );

  // {mem_req, adr_src, ir_write, alu_src_a, alu_src_b, result_src, alu_op, pcs, reg_w3, mem_w, fault}
  function automatic logic [13:0] outs();
    return {mem_req, adr_src, ir_write, alu_src_a, alu_src_b, result_src,
            alu_op, pcs, reg_w3, mem_w, fault};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // inputs set before the call take effect at this edge; check 2ns after it
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; op = 2'b00; funct = 6'd0; rd = 4'd0; mem_ready = 1'b1;

    // reset held with mem_ready=1
    #7;
    chk("reset_outs", 16'(outs()), 16'h0);
    chk("reset_state", 16'(state_dbg), 16'd0);
    tick();
    chk("reset_outs_edge", 16'(outs()), 16'h0);
    reset = 1'b1;
    #1;
    chk("rel_idle", 16'(state_dbg), 16'd0);
    tick();
    chk("fetch_state", 16'(state_dbg), 16'd1);
    // FETCH with ready: mem_req, ir_write, pcs, a=01, b=10, res=10
    chk("fetch_outs", 16'(outs()), 16'(14'b1_0_1_01_10_10_0_1_0_0_0));

    // ADD reg rd=3
    op = 2'b00; funct = 6'b000000; rd = 4'd3;
    tick(); chk("add_decode", 16'(state_dbg), 16'd2);
    chk("decode_outs", 16'(outs()), 16'(14'b0_0_0_01_10_10_0_0_0_0_0));
    tick(); chk("add_execr", 16'(state_dbg), 16'd7);
    chk("execr_outs", 16'(outs()), 16'(14'b0_0_0_00_00_00_1_0_0_0_0));
    tick(); chk("add_aluwb", 16'(state_dbg), 16'd9);
    chk("aluwb_outs", 16'(outs()), 16'(14'b0_0_0_00_00_00_0_0_1_0_0));
    tick(); chk("add_fetch", 16'(state_dbg), 16'd1);

    // ADD immediate, rd=15 -> EXECI and pcs in ALUWB
    funct = 6'b100000; rd = 4'hF;
    tick(); tick(); chk("addi_execi", 16'(state_dbg), 16'd8);
    chk("execi_outs", 16'(outs()), 16'(14'b0_0_0_00_01_00_1_0_0_0_0));
    tick(); chk("addi_pcs", 16'({reg_w3, pcs}), 16'b11);
    tick(); chk("addi_fetch", 16'(state_dbg), 16'd1);

    // load rd=5 with 2 wait cycles
    op = 2'b01; funct = 6'b000001; rd = 4'd5;
    tick(); chk("ld_decode", 16'(state_dbg), 16'd2);
    tick(); chk("ld_memadr", 16'(state_dbg), 16'd3);
    chk("memadr_outs", 16'(outs()), 16'(14'b0_0_0_00_01_00_0_0_0_0_0));
    mem_ready = 1'b0;
    tick(); chk("ld_memrd0", 16'(state_dbg), 16'd4);
    chk("memrd_outs", 16'(outs()), 16'(14'b1_1_0_00_00_00_0_0_0_0_0));
    tick(); chk("ld_memrd1", 16'(state_dbg), 16'd4);
    tick(); chk("ld_memrd2", 16'(state_dbg), 16'd4);
    mem_ready = 1'b1;
    tick(); chk("ld_memwb", 16'(state_dbg), 16'd5);
    chk("memwb_outs", 16'(outs()), 16'(14'b0_0_0_00_00_01_0_0_1_0_0));
    tick(); chk("ld_fetch", 16'(state_dbg), 16'd1);

    // zero-wait load to rd=15: MEMWB raises pcs after 4 edges from FETCH
    rd = 4'hF;
    tick(); tick(); tick(); tick();
    chk("ld15_memwb", 16'(state_dbg), 16'd5);
    chk("ld15_pcs", 16'({reg_w3, pcs}), 16'b11);
    tick();

    // store: mem_w and adr_src held through wait, no reg_w3
    funct = 6'b000000; rd = 4'd2;
    tick(); tick(); mem_ready = 1'b0;
    tick(); chk("st_memwr0", 16'(outs()), 16'(14'b1_1_0_00_00_00_0_0_0_1_0));
    chk("st_state", 16'(state_dbg), 16'd6);
    tick(); chk("st_memwr1", 16'(outs()), 16'(14'b1_1_0_00_00_00_0_0_0_1_0));
    mem_ready = 1'b1;
    tick(); chk("st_fetch", 16'(state_dbg), 16'd1);

    // branch
    op = 2'b10;
    tick(); tick(); chk("br_state", 16'(state_dbg), 16'd10);
    chk("br_outs", 16'(outs()), 16'(14'b0_0_0_00_01_10_0_1_0_0_0));
    tick(); chk("br_fetch", 16'(state_dbg), 16'd1);

    // ready arrives in the limit cycle -> DECODE, no fault
    mem_ready = 1'b0;
    #1;
    chk("fetch_stall_outs", 16'({ir_write, pcs, mem_req}), 16'b001);
    tick(); tick(); tick();
    mem_ready = 1'b1;
    #1;
    chk("limit_ready_irw", 16'(ir_write), 16'd1);
    tick(); chk("limit_decode", 16'(state_dbg), 16'd2);
    chk("limit_nofault", 16'(fault), 16'd0);
    tick(); tick(); chk("limit_refetch", 16'(state_dbg), 16'd1);

    // timeout: 4 stalled FETCH cycles then FAULT
    mem_ready = 1'b0;
    tick(); tick(); tick();
    chk("to_still_fetch", 16'(state_dbg), 16'd1);
    tick(); chk("to_fault", 16'(state_dbg), 16'd11);
    chk("to_fault_outs", 16'(outs()), 16'(14'b0_0_0_00_00_00_0_0_0_0_1));

    // illegal op -> FAULT after DECODE, sticky
    do_reset();
    op = 2'b11; mem_ready = 1'b1;
    tick(); chk("ill_fetch", 16'(state_dbg), 16'd1);
    tick(); chk("ill_decode", 16'(state_dbg), 16'd2);
    tick(); chk("ill_fault", 16'(state_dbg), 16'd11);
    op = 2'b00;
    for (int i = 0; i < 10; i++) tick();
    chk("ill_sticky", 16'(outs()), 16'(14'b0_0_0_00_00_00_0_0_0_0_1));
    chk("ill_sticky_state", 16'(state_dbg), 16'd11);

    // async reset mid-MEMWR
    do_reset();
    op = 2'b01; funct = 6'b000000; mem_ready = 1'b1;
    tick(); tick(); tick(); mem_ready = 1'b0;
    tick(); chk("ar_memwr", 16'({mem_req, mem_w}), 16'b11);
    reset = 1'b0;
    #1;
    chk("ar_drop", 16'({mem_req, mem_w}), 16'b00);
    chk("ar_idle", 16'(state_dbg), 16'd0);
    reset = 1'b1;
    tick(); chk("ar_refetch", 16'(state_dbg), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
